// File: rtl/i8254_pkg.sv
// rtl/i8254_pkg.sv - shared constants, types and helpers for the 8254 bus/control block
package i8254_pkg;

    localparam logic [1:0] ADDR_CNT0 = 2'b00;
    localparam logic [1:0] ADDR_CNT1 = 2'b01;
    localparam logic [1:0] ADDR_CNT2 = 2'b10;
    localparam logic [1:0] ADDR_CTRL = 2'b11;

    typedef enum logic [1:0] {
        RW_LATCH   = 2'b00,
        RW_LSB     = 2'b01,
        RW_MSB     = 2'b10,
        RW_LSB_MSB = 2'b11
    } rw_e;

    localparam int CW_SC_HI   = 7;
    localparam int CW_SC_LO   = 6;
    localparam int CW_RW_HI   = 5;
    localparam int CW_RW_LO   = 4;
    localparam int CW_M_HI    = 3;
    localparam int CW_M_LO    = 1;
    localparam int CW_BCD     = 0;
    localparam int RB_NOCOUNT = 5;
    localparam int RB_NOSTAT  = 4;

    typedef struct packed {
        logic       out;
        logic       null_cnt;
        rw_e        rw;
        logic [2:0] mode;
        logic       bcd;
    } status_t;

    typedef struct packed {
        logic       cs_n;
        logic       rd_n;
        logic       wr_n;
        logic [1:0] addr;
        logic [7:0] data;
    } bus_sample_t;

    localparam bus_sample_t BUS_IDLE = '{cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1, addr: 2'b00, data: 8'h00};

    // Modes 6 and 7 alias modes 2 and 3.
    function automatic logic [2:0] norm_mode(input logic [2:0] m);
        return m[1] ? {1'b0, m[1:0]} : m;
    endfunction

endpackage

// File: rtl/i8254_counter_ctl.sv
// rtl/i8254_counter_ctl.sv - per-counter control word, byte pointers, latches and null-count
module i8254_counter_ctl
    import i8254_pkg::*;
#(
    parameter logic [1:0] IDX = 2'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ctrl_wr,
    input  logic        cnt_wr,
    input  logic        cnt_rd,
    input  logic [7:0]  wr_data,
    input  logic [15:0] count,
    input  logic        out_pin,
    input  logic        loaded,
    output logic [2:0]  mode,
    output logic        bcd,
    output logic        null_count,
    output logic        ld_req,
    output logic [15:0] ld_val,
    output logic [7:0]  rd_byte
);

    localparam int RB_BIT = int'(IDX) + 1;

    rw_e         rw;
    logic        wptr, rptr;
    logic [7:0]  held;
    logic [15:0] cnt_latch;
    logic        cnt_full;
    status_t     st_latch;
    logic        st_full;

    logic [1:0]  sc, rwf;
    logic        rb_sel, own, prog, latch_cnt, latch_st;
    logic [15:0] src;

    assign sc        = wr_data[CW_SC_HI:CW_SC_LO];
    assign rwf       = wr_data[CW_RW_HI:CW_RW_LO];
    assign rb_sel    = ctrl_wr && (sc == 2'b11) && wr_data[RB_BIT];
    assign own       = ctrl_wr && (sc == IDX);
    assign prog      = own && (rwf != RW_LATCH);
    assign latch_cnt = (own && (rwf == RW_LATCH)) || (rb_sel && !wr_data[RB_NOCOUNT]);
    assign latch_st  = rb_sel && !wr_data[RB_NOSTAT];

    always_comb begin
        ld_req = cnt_wr && ((rw == RW_LSB) || (rw == RW_MSB) || ((rw == RW_LSB_MSB) && wptr));
        case (rw)
            RW_LSB:  ld_val = {8'h00, wr_data};
            RW_MSB:  ld_val = {wr_data, 8'h00};
            default: ld_val = {wr_data, held};
        endcase
    end

    // A pending status byte always goes out before any count byte.
    always_comb begin
        src = cnt_full ? cnt_latch : count;
        if (st_full) begin
            rd_byte = st_latch;
        end else begin
            case (rw)
                RW_MSB:     rd_byte = src[15:8];
                RW_LSB_MSB: rd_byte = rptr ? src[15:8] : src[7:0];
                default:    rd_byte = src[7:0];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rw         <= RW_LATCH;
            mode       <= 3'd0;
            bcd        <= 1'b0;
            wptr       <= 1'b0;
            rptr       <= 1'b0;
            held       <= 8'h00;
            cnt_latch  <= 16'h0000;
            cnt_full   <= 1'b0;
            st_latch   <= '0;
            st_full    <= 1'b0;
            null_count <= 1'b0;
        end else begin
            if (prog) begin
                rw       <= rw_e'(rwf);
                mode     <= norm_mode(wr_data[CW_M_HI:CW_M_LO]);
                bcd      <= wr_data[CW_BCD];
                wptr     <= 1'b0;
                rptr     <= 1'b0;
                cnt_full <= 1'b0;
                st_full  <= 1'b0;
            end else begin
                if (latch_cnt && !cnt_full) begin
                    cnt_latch <= count;
                    cnt_full  <= 1'b1;
                end
                if (latch_st && !st_full) begin
                    st_latch <= {out_pin, null_count, rw, mode, bcd};
                    st_full  <= 1'b1;
                end
                if (cnt_wr && (rw == RW_LSB_MSB)) begin
                    if (!wptr) held <= wr_data;
                    wptr <= !wptr;
                end
                if (cnt_rd) begin
                    if (st_full) begin
                        st_full <= 1'b0;
                    end else if (rw == RW_LSB_MSB) begin
                        rptr <= !rptr;
                        if (rptr) cnt_full <= 1'b0;
                    end else begin
                        cnt_full <= 1'b0;
                    end
                end
            end
            if (prog || ld_req) null_count <= 1'b1;
            else if (loaded)    null_count <= 1'b0;
        end
    end

endmodule

// File: rtl/i8254_bus_control.sv
// rtl/i8254_bus_control.sv - 8254 CPU bus interface: pin sync, access framing, decode, read mux
module i8254_bus_control
    import i8254_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    input  logic        a0,
    input  logic        a1,
    input  logic        cs_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic [47:0] count_val,
    input  logic [2:0]  out_state,
    input  logic [2:0]  cnt_loaded,
    output logic [8:0]  cw_mode,
    output logic [2:0]  cw_bcd,
    output logic [15:0] load_value,
    output logic [2:0]  load_strobe,
    output logic [2:0]  null_count
);

    bus_sample_t sync_q [SYNC_STAGES];
    bus_sample_t cur, prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= BUS_IDLE;
            prev <= BUS_IDLE;
        end else begin
            sync_q[0] <= {cs_n, rd_n, wr_n, a1, a0, data_in};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev <= cur;
        end
    end

    assign cur = sync_q[SYNC_STAGES-1];

    // Strobe edges commit using the address/data of the last sample before the edge.
    logic legal, wr_commit, rd_commit, rd_active;
    assign legal     = !prev.cs_n && (prev.rd_n || prev.wr_n);
    assign wr_commit = legal && !prev.wr_n && cur.wr_n;
    assign rd_commit = legal && !prev.rd_n && cur.rd_n;
    assign rd_active = !cur.cs_n && !cur.rd_n && cur.wr_n && (cur.addr != ADDR_CTRL);

    logic [2:0]  ld_req;
    logic [15:0] ld_val  [3];
    logic [7:0]  rd_byte [3];

    for (genvar g = 0; g < 3; g++) begin : g_cnt
        i8254_counter_ctl #(.IDX(2'(g))) u_ctl (
            .clk        (clk),
            .rst        (rst),
            .ctrl_wr    (wr_commit && (prev.addr == ADDR_CTRL)),
            .cnt_wr     (wr_commit && (prev.addr == 2'(g))),
            .cnt_rd     (rd_commit && (prev.addr == 2'(g))),
            .wr_data    (prev.data),
            .count      (count_val[16*g +: 16]),
            .out_pin    (out_state[g]),
            .loaded     (cnt_loaded[g]),
            .mode       (cw_mode[3*g +: 3]),
            .bcd        (cw_bcd[g]),
            .null_count (null_count[g]),
            .ld_req     (ld_req[g]),
            .ld_val     (ld_val[g]),
            .rd_byte    (rd_byte[g])
        );
    end

    logic [15:0] ld_sel;
    logic [7:0]  rd_sel;

    always_comb begin
        ld_sel = load_value;
        for (int n = 0; n < 3; n++) begin
            if (ld_req[n]) ld_sel = ld_val[n];
        end
        case (cur.addr)
            ADDR_CNT0: rd_sel = rd_byte[0];
            ADDR_CNT1: rd_sel = rd_byte[1];
            ADDR_CNT2: rd_sel = rd_byte[2];
            default:   rd_sel = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_strobe <= 3'b000;
            load_value  <= 16'h0000;
            data_oe     <= 1'b0;
            data_out    <= 8'h00;
        end else begin
            load_strobe <= ld_req;
            load_value  <= ld_sel;
            data_oe     <= rd_active;
            data_out    <= rd_active ? rd_sel : 8'h00;
        end
    end

endmodule
